divsqrt_share_arb: RTL and testbench
====================================

DIVSQRT_SHARE_ARB -- requirements
Module: divsqrt_share_arb

Interface
REQ-001 SHALL have parameter MAX_LAT, default 63, giving the watchdog limit in cycles from issue to completion; legal range 2..255.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have, for each requester k in {0,1}, these inputs: io_reqk_valid (1), io_reqk_sqrtOp (1), io_reqk_a (33, recoded FN), io_reqk_b (33), io_reqk_roundingMode (3).
REQ-005 SHALL have, for each requester k, output io_reqk_ready (1): the request is accepted this cycle.
REQ-006 SHALL have, for each requester k, outputs io_respk_valid (1) and io_respk_isSqrt (1): a completion pulse routed to the owning requester, and its op type.
REQ-007 SHALL have shared-unit outputs io_du_inValid (1), io_du_sqrtOp (1), io_du_a (33), io_du_b (33) and io_du_roundingMode (3).
REQ-008 SHALL have shared-unit inputs io_du_inReady (1), io_du_rawOutValid_div (1) and io_du_rawOutValid_sqrt (1).
REQ-009 SHALL have status outputs io_busy (1), io_owner (1, index of the in-flight requester) and io_err (1, sticky).

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and BUSY; reset state is IDLE.
REQ-011 SHALL, in IDLE, grant combinationally: if one valid, grant it; if both valid, grant the requester selected by round-robin pointer rr (reset 0).
REQ-012 SHALL drive io_du_inValid = IDLE & (io_req0_valid | io_req1_valid), with io_du_* operands muxed from the granted requester; operands are 0 when nothing is granted.
REQ-013 SHALL drive io_reqk_ready = IDLE & grant==k & io_du_inReady; all readies are 0 in BUSY.
REQ-014 SHALL, on a transfer (inValid & inReady in IDLE), move to BUSY next cycle, latch owner=k, latch opSqrt=sqrtOp, set rr = ~k and clear the watchdog counter wd.
REQ-015 SHALL, in BUSY, increment 8-bit wd each cycle.
REQ-016 SHALL, in BUSY, treat io_du_rawOutValid_div | io_du_rawOutValid_sqrt as completion: pulse io_resp{owner}_valid combinationally in the same cycle with isSqrt = io_du_rawOutValid_sqrt, and return to IDLE next cycle.
REQ-017 SHALL hold the minimum issue spacing at 2 cycles: no issue in the completion cycle; next issue is possible in the following IDLE cycle.
REQ-018 SHALL set io_err on any of: completion type ≠ latched opSqrt; completion while in IDLE (ignored, no resp pulse); both rawOutValid inputs high in one cycle (isSqrt=1 reported).
REQ-019 SHALL, when wd reaches MAX_LAT in BUSY without completion, set io_err, return to IDLE next cycle, and emit no resp; a late completion is then handled as stray per REQ-018.
REQ-020 SHALL keep io_err sticky until reset.
REQ-021 SHALL drive io_busy = BUSY and io_owner = latched owner (0 after reset); io_respk_valid SHALL never be asserted for both k in the same cycle.

Reset
REQ-022 SHALL, on reset, synchronously clear: state=IDLE, rr=0, owner=0, opSqrt=0, wd=0, io_err=0; all io_reqk_ready, io_respk_valid and io_du_inValid outputs SHALL be 0 during the reset cycle.
REQ-023 SHALL, on reset asserted in BUSY, abandon the in-flight op with no resp pulse; a completion in the first post-reset cycle SHALL be treated as stray.

Verification
REQ-024 Single request: req0 div valid, inReady=1, completion 10 cycles later -> req0_ready pulses 1 cycle, busy 10 cycles, resp0_valid=1 and isSqrt=0 in the completion cycle, err=0.
REQ-025 Contention: both valid continuously with immediate completions -> grants alternate 0,1,0,1 starting with 0; each resp goes to the matching owner.
REQ-026 Backpressure: req1 valid with inReady=0 for 5 cycles -> du_inValid=1 and ready1=0 for those cycles; transfer occurs on the first cycle inReady=1.
REQ-027 Watchdog, MAX_LAT=4: issue with no completion -> err=1 and return to IDLE after 4 BUSY cycles; a later rawOutValid_div produces no resp.
REQ-028 Mismatch and reset: issue sqrt, complete with rawOutValid_div -> resp0_valid with isSqrt=0 and err=1; then assert reset mid-BUSY -> err=0, busy=0 next cycle.

Source files
------------

// File: rtl/divsqrt_share_arb_if.sv
// Bundle for the divsqrt sharing arbiter: two requester ports, shared-unit port, status.
// A request transfers in the cycle where io_reqk_valid & io_reqk_ready are both high; the shared unit
// takes an operation when io_du_inValid & io_du_inReady; completions are single-cycle pulses with no backpressure.
interface divsqrt_share_arb_if;
  logic        io_req0_valid;
  logic        io_req0_sqrtOp;
  logic [32:0] io_req0_a;
  logic [32:0] io_req0_b;
  logic [2:0]  io_req0_roundingMode;
  logic        io_req0_ready;
  logic        io_req1_valid;
  logic        io_req1_sqrtOp;
  logic [32:0] io_req1_a;
  logic [32:0] io_req1_b;
  logic [2:0]  io_req1_roundingMode;
  logic        io_req1_ready;
  logic        io_resp0_valid;
  logic        io_resp0_isSqrt;
  logic        io_resp1_valid;
  logic        io_resp1_isSqrt;
  logic        io_du_inValid;
  logic        io_du_sqrtOp;
  logic [32:0] io_du_a;
  logic [32:0] io_du_b;
  logic [2:0]  io_du_roundingMode;
  logic        io_du_inReady;
  logic        io_du_rawOutValid_div;
  logic        io_du_rawOutValid_sqrt;
  logic        io_busy;
  logic        io_owner;
  logic        io_err;

  modport master (
    output io_req0_valid, io_req0_sqrtOp, io_req0_a, io_req0_b, io_req0_roundingMode,
    output io_req1_valid, io_req1_sqrtOp, io_req1_a, io_req1_b, io_req1_roundingMode,
    output io_du_inReady, io_du_rawOutValid_div, io_du_rawOutValid_sqrt,
    input  io_req0_ready, io_req1_ready,
    input  io_resp0_valid, io_resp0_isSqrt, io_resp1_valid, io_resp1_isSqrt,
    input  io_du_inValid, io_du_sqrtOp, io_du_a, io_du_b, io_du_roundingMode,
    input  io_busy, io_owner, io_err
  );

  modport slave (
    input  io_req0_valid, io_req0_sqrtOp, io_req0_a, io_req0_b, io_req0_roundingMode,
    input  io_req1_valid, io_req1_sqrtOp, io_req1_a, io_req1_b, io_req1_roundingMode,
    input  io_du_inReady, io_du_rawOutValid_div, io_du_rawOutValid_sqrt,
    output io_req0_ready, io_req1_ready,
    output io_resp0_valid, io_resp0_isSqrt, io_resp1_valid, io_resp1_isSqrt,
    output io_du_inValid, io_du_sqrtOp, io_du_a, io_du_b, io_du_roundingMode,
    output io_busy, io_owner, io_err
  );
endinterface

// File: rtl/divsqrt_share_arb.sv
// Shares one divide/sqrt unit between two requesters: round-robin issue, one op in flight,
// completion routing to the owner, watchdog timeout and a sticky protocol-error flag.
module divsqrt_share_arb #(
  parameter int MAX_LAT = 63
) (
  input  logic                 clock,
  input  logic                 reset,
  divsqrt_share_arb_if.slave   bus,
  output logic                 dbg_state
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] LAT = 8'(MAX_LAT);

  state_t     state, state_next;
  logic       rr, owner, op_sqrt, err;
  logic [7:0] wd;

  logic any_req, raw_any, raw_both;
  logic grant, grant_ok, xfer, done, timeout, err_set;

  assign any_req  = bus.io_req0_valid | bus.io_req1_valid;
  assign raw_any  = bus.io_du_rawOutValid_div | bus.io_du_rawOutValid_sqrt;
  assign raw_both = bus.io_du_rawOutValid_div & bus.io_du_rawOutValid_sqrt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= 1'b0;
      owner   <= 1'b0;
      op_sqrt <= 1'b0;
      wd      <= 8'd0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer) begin
        owner   <= grant;
        op_sqrt <= bus.io_du_sqrtOp;
        rr      <= ~grant;
        wd      <= 8'd0;
      end else if (state == BUSY) begin
        wd <= wd + 8'd1;
      end
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_ok   = 1'b0;
    xfer       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        grant_ok = any_req & ~reset;
        grant    = (bus.io_req0_valid & bus.io_req1_valid) ? rr : bus.io_req1_valid;
        xfer     = grant_ok & bus.io_du_inReady;
        if (xfer) state_next = BUSY;
        // A completion with nothing in flight is stray: flag it, never route it.
        if (raw_any) err_set = 1'b1;
      end
      BUSY: begin
        done    = raw_any & ~reset;
        // wd counts from 0 in the first BUSY cycle, so the last allowed cycle sees MAX_LAT-1.
        timeout = ~raw_any & ((wd + 8'd1) == LAT);
        if (raw_any | timeout) state_next = IDLE;
        if (raw_any & (raw_both | (bus.io_du_rawOutValid_sqrt != op_sqrt))) err_set = 1'b1;
        if (timeout) err_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.io_du_sqrtOp       = 1'b0;
    bus.io_du_a            = 33'd0;
    bus.io_du_b            = 33'd0;
    bus.io_du_roundingMode = 3'd0;
    if (grant_ok) begin
      bus.io_du_sqrtOp       = grant ? bus.io_req1_sqrtOp       : bus.io_req0_sqrtOp;
      bus.io_du_a            = grant ? bus.io_req1_a            : bus.io_req0_a;
      bus.io_du_b            = grant ? bus.io_req1_b            : bus.io_req0_b;
      bus.io_du_roundingMode = grant ? bus.io_req1_roundingMode : bus.io_req0_roundingMode;
    end
  end

  assign bus.io_du_inValid   = grant_ok;
  assign bus.io_req0_ready   = xfer & ~grant;
  assign bus.io_req1_ready   = xfer & grant;
  assign bus.io_resp0_valid  = done & ~owner;
  assign bus.io_resp1_valid  = done & owner;
  assign bus.io_resp0_isSqrt = done & ~owner & bus.io_du_rawOutValid_sqrt;
  assign bus.io_resp1_isSqrt = done & owner & bus.io_du_rawOutValid_sqrt;
  assign bus.io_busy         = (state == BUSY);
  assign bus.io_owner        = owner;
  assign bus.io_err          = err;
  assign dbg_state           = state;
endmodule

// File: tb/tb_divsqrt_share_arb.sv
// Bench for divsqrt_share_arb: a cycle-level model checked every cycle for two instances
// (default watchdog and MAX_LAT=4), plus directed scenarios with literal expectations.
module tb_divsqrt_share_arb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dbg_m, dbg_w;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  divsqrt_share_arb_if bus ();
  divsqrt_share_arb_if wbus ();

  divsqrt_share_arb dut (.clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_m));
  divsqrt_share_arb #(.MAX_LAT(4)) dut_wd (.clock(clock), .reset(reset), .bus(wbus), .dbg_state(dbg_w));

  typedef struct packed {
    logic v0, v1, s0, s1;
    logic [32:0] a0, b0, a1, b1;
    logic [2:0] rm0, rm1;
    logic in_ready, rvd, rvs;
  } min_t;

  typedef struct packed {
    logic ready0, ready1, resp0, resp1, iss0, iss1, du_v, du_s;
    logic [32:0] du_a, du_b;
    logic [2:0] du_rm;
    logic busy, owner, err;
  } mout_t;

  // Model state: whether an op is in flight, who owns it, its type, and how many BUSY cycles elapsed.
  typedef struct packed {
    logic busy, owner, op, rr, err;
    int age;
  } mstate_t;

  function automatic void model_step(input int max_lat, input logic rst, input min_t i,
                                     input mstate_t s, output mstate_t ns, output mout_t o);
    logic any, g;
    ns = s;
    o = '0;
    o.busy = s.busy;
    o.owner = s.owner;
    o.err = s.err;
    if (rst) begin
      ns = '0;
    end else if (!s.busy) begin
      any = i.v0 | i.v1;
      g = (i.v0 && i.v1) ? s.rr : i.v1;
      if (i.rvd || i.rvs) ns.err = 1'b1;
      if (any) begin
        o.du_v = 1'b1;
        o.du_s = g ? i.s1 : i.s0;
        o.du_a = g ? i.a1 : i.a0;
        o.du_b = g ? i.b1 : i.b0;
        o.du_rm = g ? i.rm1 : i.rm0;
        if (i.in_ready) begin
          o.ready0 = !g;
          o.ready1 = g;
          ns.busy = 1'b1;
          ns.owner = g;
          ns.op = o.du_s;
          ns.rr = !g;
          ns.age = 0;
        end
      end
    end else if (i.rvd || i.rvs) begin
      o.resp0 = !s.owner;
      o.resp1 = s.owner;
      o.iss0 = !s.owner && i.rvs;
      o.iss1 = s.owner && i.rvs;
      if ((i.rvd && i.rvs) || (i.rvs != s.op)) ns.err = 1'b1;
      ns.busy = 1'b0;
    end else begin
      ns.age = s.age + 1;
      if (ns.age >= max_lat) begin
        ns.err = 1'b1;
        ns.busy = 1'b0;
      end
    end
  endfunction

  function automatic min_t in_main();
    min_t i;
    i.v0 = bus.io_req0_valid; i.v1 = bus.io_req1_valid;
    i.s0 = bus.io_req0_sqrtOp; i.s1 = bus.io_req1_sqrtOp;
    i.a0 = bus.io_req0_a; i.b0 = bus.io_req0_b; i.a1 = bus.io_req1_a; i.b1 = bus.io_req1_b;
    i.rm0 = bus.io_req0_roundingMode; i.rm1 = bus.io_req1_roundingMode;
    i.in_ready = bus.io_du_inReady;
    i.rvd = bus.io_du_rawOutValid_div; i.rvs = bus.io_du_rawOutValid_sqrt;
    return i;
  endfunction

  function automatic min_t in_wd();
    min_t i;
    i.v0 = wbus.io_req0_valid; i.v1 = wbus.io_req1_valid;
    i.s0 = wbus.io_req0_sqrtOp; i.s1 = wbus.io_req1_sqrtOp;
    i.a0 = wbus.io_req0_a; i.b0 = wbus.io_req0_b; i.a1 = wbus.io_req1_a; i.b1 = wbus.io_req1_b;
    i.rm0 = wbus.io_req0_roundingMode; i.rm1 = wbus.io_req1_roundingMode;
    i.in_ready = wbus.io_du_inReady;
    i.rvd = wbus.io_du_rawOutValid_div; i.rvs = wbus.io_du_rawOutValid_sqrt;
    return i;
  endfunction

  function automatic mout_t out_main();
    mout_t o;
    o.ready0 = bus.io_req0_ready; o.ready1 = bus.io_req1_ready;
    o.resp0 = bus.io_resp0_valid; o.resp1 = bus.io_resp1_valid;
    o.iss0 = bus.io_resp0_isSqrt; o.iss1 = bus.io_resp1_isSqrt;
    o.du_v = bus.io_du_inValid; o.du_s = bus.io_du_sqrtOp;
    o.du_a = bus.io_du_a; o.du_b = bus.io_du_b; o.du_rm = bus.io_du_roundingMode;
    o.busy = bus.io_busy; o.owner = bus.io_owner; o.err = bus.io_err;
    return o;
  endfunction

  function automatic mout_t out_wd();
    mout_t o;
    o.ready0 = wbus.io_req0_ready; o.ready1 = wbus.io_req1_ready;
    o.resp0 = wbus.io_resp0_valid; o.resp1 = wbus.io_resp1_valid;
    o.iss0 = wbus.io_resp0_isSqrt; o.iss1 = wbus.io_resp1_isSqrt;
    o.du_v = wbus.io_du_inValid; o.du_s = wbus.io_du_sqrtOp;
    o.du_a = wbus.io_du_a; o.du_b = wbus.io_du_b; o.du_rm = wbus.io_du_roundingMode;
    o.busy = wbus.io_busy; o.owner = wbus.io_owner; o.err = wbus.io_err;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_unit(input string tag, input mout_t a, input mout_t e);
    check({tag, ".ready0"}, a.ready0, e.ready0);
    check({tag, ".ready1"}, a.ready1, e.ready1);
    check({tag, ".resp0"}, a.resp0, e.resp0);
    check({tag, ".resp1"}, a.resp1, e.resp1);
    check({tag, ".isSqrt0"}, a.iss0, e.iss0);
    check({tag, ".isSqrt1"}, a.iss1, e.iss1);
    check({tag, ".du_inValid"}, a.du_v, e.du_v);
    check({tag, ".du_sqrtOp"}, a.du_s, e.du_s);
    check({tag, ".du_a"}, a.du_a, e.du_a);
    check({tag, ".du_b"}, a.du_b, e.du_b);
    check({tag, ".du_rm"}, a.du_rm, e.du_rm);
    check({tag, ".busy"}, a.busy, e.busy);
    check({tag, ".owner"}, a.owner, e.owner);
    check({tag, ".err"}, a.err, e.err);
  endtask

  // Model compare: inputs are stable from negedge to the next posedge, so the model steps here.
  initial begin
    mstate_t sm, sw, nsm, nsw;
    mout_t em, ew;
    @(posedge clock);
    sm = '0;
    sw = '0;
    forever begin
      @(negedge clock);
      model_step(63, reset, in_main(), sm, nsm, em);
      compare_unit("main", out_main(), em);
      sm = nsm;
      model_step(4, reset, in_wd(), sw, nsw, ew);
      compare_unit("wd", out_wd(), ew);
      sw = nsw;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_main();
    bus.io_req0_valid = 0; bus.io_req0_sqrtOp = 0; bus.io_req0_a = '0; bus.io_req0_b = '0;
    bus.io_req0_roundingMode = '0;
    bus.io_req1_valid = 0; bus.io_req1_sqrtOp = 0; bus.io_req1_a = '0; bus.io_req1_b = '0;
    bus.io_req1_roundingMode = '0;
    bus.io_du_inReady = 0; bus.io_du_rawOutValid_div = 0; bus.io_du_rawOutValid_sqrt = 0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1;
    zero_main();
    cyc();
    reset = 0;
  endtask

  logic [32:0] a0_val = 33'h1_0000_0001;
  logic [32:0] a1_val = 33'h0_1234_5678;
  int busy_cnt = 0;

  initial begin
    zero_main();
    wbus.io_req0_valid = 0; wbus.io_req0_sqrtOp = 0; wbus.io_req0_a = '0; wbus.io_req0_b = '0;
    wbus.io_req0_roundingMode = '0;
    wbus.io_req1_valid = 0; wbus.io_req1_sqrtOp = 0; wbus.io_req1_a = '0; wbus.io_req1_b = '0;
    wbus.io_req1_roundingMode = '0;
    wbus.io_du_inReady = 0; wbus.io_du_rawOutValid_div = 0; wbus.io_du_rawOutValid_sqrt = 0;
    bus.io_req0_valid = 1;
    bus.io_du_inReady = 1;

    // Reset cycle: a pending request must not leak through.
    cyc(); #2;
    check("rst.du_inValid", bus.io_du_inValid, 0);
    check("rst.ready0", bus.io_req0_ready, 0);
    check("rst.busy", bus.io_busy, 0);
    check("rst.err", bus.io_err, 0);
    check("rst.owner", bus.io_owner, 0);
    check("rst.state", dbg_m, 0);

    // Single divide from req0 completing 10 cycles after issue.
    cyc();
    reset = 0;
    bus.io_req0_a = 33'h0_4000_0000; bus.io_req0_b = 33'h0_3f80_0000; bus.io_req0_roundingMode = 3'd2;
    #2;
    check("single.ready0", bus.io_req0_ready, 1);
    check("single.du_a", bus.io_du_a, 33'h0_4000_0000);
    check("single.du_rm", bus.io_du_roundingMode, 3'd2);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      bus.io_req0_valid = 0;
      bus.io_du_rawOutValid_div = (c == 10);
      #2;
      busy_cnt += int'(bus.io_busy);
      check("single.ready0_busy", bus.io_req0_ready, 0);
      if (c == 10) begin
        check("single.resp", {bus.io_resp1_valid, bus.io_resp0_valid}, 2'b01);
        check("single.isSqrt0", bus.io_resp0_isSqrt, 0);
      end
    end
    cyc();
    bus.io_du_rawOutValid_div = 0;
    #2;
    check("single.busy_cycles", busy_cnt, 10);
    check("single.busy_after", bus.io_busy, 0);
    check("single.err", bus.io_err, 0);

    // Contention with immediate completions: grants alternate starting with requester 0.
    do_reset();
    bus.io_req0_valid = 1; bus.io_req1_valid = 1;
    bus.io_req0_a = a0_val; bus.io_req1_a = a1_val;
    bus.io_du_inReady = 1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      bus.io_du_rawOutValid_div = (i % 2 == 1);
      #2;
      if (i % 2 == 0) begin
        check("rr.grant", {bus.io_req1_ready, bus.io_req0_ready}, ((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
        check("rr.du_a", bus.io_du_a, ((i / 2) % 2 == 1) ? a1_val : a0_val);
      end else begin
        check("rr.resp", {bus.io_resp1_valid, bus.io_resp0_valid}, ((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
      end
    end

    // Backpressure: req1 sqrt held 5 cycles by inReady=0.
    cyc();
    zero_main();
    bus.io_req1_valid = 1; bus.io_req1_sqrtOp = 1; bus.io_req1_a = a1_val;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) cyc();
      #2;
      check("bp.du_inValid", bus.io_du_inValid, 1);
      check("bp.ready1", bus.io_req1_ready, 0);
    end
    cyc();
    bus.io_du_inReady = 1;
    #2;
    check("bp.ready1_go", bus.io_req1_ready, 1);
    cyc();
    bus.io_req1_valid = 0;
    bus.io_du_rawOutValid_sqrt = 1;
    #2;
    check("bp.owner", bus.io_owner, 1);
    check("bp.resp", {bus.io_resp1_valid, bus.io_resp0_valid}, 2'b10);
    check("bp.isSqrt1", bus.io_resp1_isSqrt, 1);
    cyc();
    bus.io_du_rawOutValid_sqrt = 0;
    #2;
    check("bp.err", bus.io_err, 0);

    // Type mismatch: sqrt issued, divide completion reported.
    do_reset();
    bus.io_req0_valid = 1; bus.io_req0_sqrtOp = 1; bus.io_du_inReady = 1;
    #2;
    check("mm.ready0", bus.io_req0_ready, 1);
    cyc();
    bus.io_req0_valid = 0;
    bus.io_du_rawOutValid_div = 1;
    #2;
    check("mm.resp0", bus.io_resp0_valid, 1);
    check("mm.isSqrt0", bus.io_resp0_isSqrt, 0);
    cyc();
    bus.io_du_rawOutValid_div = 0;
    bus.io_req0_valid = 1; bus.io_req0_sqrtOp = 0;
    #2;
    check("mm.err", bus.io_err, 1);
    // Reset mid-BUSY, then a completion in the first post-reset cycle is stray.
    cyc();
    bus.io_req0_valid = 0;
    reset = 1;
    bus.io_du_rawOutValid_div = 1;
    #2;
    check("rb.resp0_in_reset", bus.io_resp0_valid, 0);
    cyc();
    reset = 0;
    #2;
    check("rb.err_cleared", bus.io_err, 0);
    check("rb.busy_cleared", bus.io_busy, 0);
    check("rb.stray_resp0", bus.io_resp0_valid, 0);
    cyc();
    bus.io_du_rawOutValid_div = 0;
    #2;
    check("rb.stray_err", bus.io_err, 1);

    // Both completion strobes in one cycle: reported as sqrt and flagged.
    do_reset();
    bus.io_req0_valid = 1; bus.io_req0_sqrtOp = 1; bus.io_du_inReady = 1;
    cyc();
    bus.io_req0_valid = 0;
    bus.io_du_rawOutValid_div = 1; bus.io_du_rawOutValid_sqrt = 1;
    #2;
    check("both.resp0", bus.io_resp0_valid, 1);
    check("both.isSqrt0", bus.io_resp0_isSqrt, 1);
    cyc();
    bus.io_du_rawOutValid_div = 0; bus.io_du_rawOutValid_sqrt = 0;
    #2;
    check("both.err", bus.io_err, 1);

    // Watchdog on the MAX_LAT=4 instance.
    do_reset();
    wbus.io_req0_valid = 1; wbus.io_du_inReady = 1;
    #2;
    check("wd.ready0", wbus.io_req0_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      wbus.io_req0_valid = 0;
      #2;
      check("wd.busy", wbus.io_busy, 1);
      check("wd.err_early", wbus.io_err, 0);
    end
    cyc(); #2;
    check("wd.busy_after", wbus.io_busy, 0);
    check("wd.state_after", dbg_w, 0);
    check("wd.err", wbus.io_err, 1);
    cyc();
    wbus.io_du_rawOutValid_div = 1;
    #2;
    check("wd.late_resp0", wbus.io_resp0_valid, 0);
    cyc();
    wbus.io_du_rawOutValid_div = 0;
    #2;
    check("wd.err_sticky", wbus.io_err, 1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
